prbs_checker: RTL and testbench

- Receive-side counterpart to the PRBS generator: accepts a serial bitstream one bit per enabled cycle, self-synchronises a local LFSR to it, then checks every later bit against the local prediction.
- Reports lock, per-bit error pulses, saturating error and bit counters, and a single pass flag.
- Sits at the far end of the generator in loopback and link test benches; the two blocks share the polynomial convention below.

---
 rtl/prbs_checker.sv | 138 +++++++++++++
 tb/tb_prbs_checker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS receive checker with lock, error pulses and saturating counters.
// Defining PRBS_INVERT_EN adds an invert input that XORs the received bit before checking.
module prbs_checker #(
  parameter int WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS = 7'h60,
  parameter int CNT_W = 16,
  parameter int LOCK_THRESH = 16,
  parameter int WINDOW = 64,
  parameter int LOSS_THRESH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             din,
`ifdef PRBS_INVERT_EN
  input  logic             invert,
`endif
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count,
  output logic             pass
);
  localparam int SEED_W = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
  localparam int WIN_W = $clog2(WINDOW);
  localparam int LOSS_W = $clog2(LOSS_THRESH + 1);
  typedef enum logic [1:0] {SEED, SYNC, LOCKED} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] s, s_n, seed_s, pred_s;
  logic [SEED_W-1:0] seed_cnt, seed_cnt_n;
  logic [MATCH_W-1:0] match_cnt, match_cnt_n;
  logic [WIN_W-1:0] win_cnt, win_cnt_n;
  logic [LOSS_W-1:0] win_err, win_err_n, win_err_inc;
  logic [CNT_W-1:0] err_count_n, bit_count_n;
  logic locked_n, err_pulse_n, pass_n, b, p, hit, win_end;
`ifdef PRBS_INVERT_EN
  assign b = din ^ invert;
`else
  assign b = din;
`endif
  assign p = ^(s & TAPS);
  assign hit = b == p;
  assign seed_s = {s[WIDTH-2:0], b};
  assign pred_s = {s[WIDTH-2:0], p};
  assign win_err_inc = win_err + LOSS_W'(!hit);
  assign win_end = win_cnt == WIN_W'(WINDOW - 1);
  always_comb begin
    state_n = state;
    s_n = s;
    seed_cnt_n = seed_cnt;
    match_cnt_n = match_cnt;
    win_cnt_n = win_cnt;
    win_err_n = win_err;
    err_count_n = err_count;
    bit_count_n = bit_count;
    locked_n = locked;
    err_pulse_n = 1'b0;
    if (en) begin
      case (state)
        SEED: begin
          s_n = seed_s;
          seed_cnt_n = seed_cnt + 1'b1;
          if (seed_cnt == SEED_W'(WIDTH - 1)) begin
            seed_cnt_n = '0;
            match_cnt_n = '0;
            state_n = seed_s != '0 ? SYNC : SEED;
          end
        end
        SYNC: begin
          if (hit) begin
            s_n = pred_s;
            match_cnt_n = match_cnt + 1'b1;
            if (match_cnt == MATCH_W'(LOCK_THRESH - 1)) begin
              state_n = LOCKED;
              locked_n = 1'b1;
              err_count_n = '0;
              bit_count_n = '0;
              win_cnt_n = '0;
              win_err_n = '0;
            end
          end else begin
            // the offending bit becomes the first bit of a fresh seed
            state_n = SEED;
            s_n = seed_s;
            seed_cnt_n = SEED_W'(1);
          end
        end
        LOCKED: begin
          s_n = pred_s;
          bit_count_n = bit_count + CNT_W'(bit_count != '1);
          err_pulse_n = !hit;
          err_count_n = err_count + CNT_W'(!hit && err_count != '1);
          win_cnt_n = win_end ? '0 : win_cnt + 1'b1;
          win_err_n = win_end ? '0 : win_err_inc;
          if (win_err_inc == LOSS_W'(LOSS_THRESH)) begin
            state_n = SEED;
            locked_n = 1'b0;
          end
        end
        default: state_n = SEED;
      endcase
    end
    if (clear) begin
      err_count_n = '0;
      bit_count_n = '0;
    end
    pass_n = locked_n && err_count_n == '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEED;
      s <= '0;
      seed_cnt <= '0;
      match_cnt <= '0;
      win_cnt <= '0;
      win_err <= '0;
      err_count <= '0;
      bit_count <= '0;
      locked <= 1'b0;
      err_pulse <= 1'b0;
      pass <= 1'b0;
    end else begin
      state <= state_n;
      s <= s_n;
      seed_cnt <= seed_cnt_n;
      match_cnt <= match_cnt_n;
      win_cnt <= win_cnt_n;
      win_err <= win_err_n;
      err_count <= err_count_n;
      bit_count <= bit_count_n;
      locked <= locked_n;
      err_pulse <= err_pulse_n;
      pass <= pass_n;
    end
  end
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: randomized PRBS7 stimulus checked every cycle against a history-queue reference model.
module tb_prbs_checker;
  localparam logic [6:0] TAPS = 7'h60;
  logic clk = 0, reset = 1, en = 0, din = 0, clear = 0;
  logic locked, err_pulse, pass;
  logic [15:0] err_count, bit_count;
  int tests = 0, fails = 0;
`ifdef PRBS_INVERT_EN
  logic invert = 0;
`endif
  always #5 clk = ~clk;
  prbs_checker dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .din(din),
`ifdef PRBS_INVERT_EN
    .invert(invert),
`endif
    .clear(clear),
    .locked(locked),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .bit_count(bit_count),
    .pass(pass)
  );
  logic [6:0] g = 7'h01;
  logic hist[$];
  int phase = 0, nseed = 0, nmatch = 0, wpos = 0, werr = 0, m_ec = 0, m_bc = 0;
  logic m_lock = 0, m_pulse = 0, m_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic next_gen();
    logic nb = ^(g & TAPS);
    g = {g[5:0], nb};
    return nb;
  endfunction
  function automatic logic pred();
    logic r = 0;
    for (int i = 0; i < 7; i++) if (TAPS[i]) r ^= hist[hist.size() - 1 - i];
    return r;
  endfunction
  function automatic void push(input logic x);
    hist.push_back(x);
    if (hist.size() > 7) void'(hist.pop_front());
  endfunction
  task automatic model(input logic r, input logic e, input logic d, input logic c);
    logic pb, nz;
    m_pulse = 0;
    if (r) begin
      phase = 0; nseed = 0; nmatch = 0; wpos = 0; werr = 0;
      hist.delete();
      m_lock = 0; m_ec = 0; m_bc = 0; m_pass = 0;
      return;
    end
    if (e) begin
      if (phase == 0) begin
        push(d);
        nseed++;
        if (nseed == 7) begin
          nseed = 0;
          nz = 0;
          foreach (hist[i]) nz |= hist[i];
          if (nz) begin phase = 1; nmatch = 0; end
        end
      end else if (phase == 1) begin
        pb = pred();
        if (d == pb) begin
          push(pb);
          nmatch++;
          if (nmatch == 16) begin
            phase = 2; m_lock = 1; m_ec = 0; m_bc = 0; wpos = 0; werr = 0;
          end
        end else begin
          phase = 0; push(d); nseed = 1;
        end
      end else begin
        pb = pred();
        push(pb);
        if (m_bc < 65535) m_bc++;
        if (d != pb) begin
          m_pulse = 1;
          if (m_ec < 65535) m_ec++;
          werr++;
        end
        if (werr == 4) begin phase = 0; m_lock = 0; end
        wpos++;
        if (wpos == 64) begin wpos = 0; werr = 0; end
      end
    end
    if (c) begin m_ec = 0; m_bc = 0; end
    m_pass = m_lock && m_ec == 0;
  endtask
  task automatic cyc(input logic r, input logic e, input logic d, input logic c);
    reset = r; en = e; din = d; clear = c;
    @(posedge clk);
    model(r, e, d, c);
    @(negedge clk);
    chk("locked", locked, m_lock);
    chk("err_pulse", err_pulse, m_pulse);
    chk("err_count", err_count, m_ec);
    chk("bit_count", bit_count, m_bc);
    chk("pass", pass, m_pass);
  endtask
  task automatic feed(input int n, input int flip_every);
    logic bb;
    for (int k = 0; k < n; k++) begin
      bb = next_gen();
      cyc(0, 1, bb ^ (flip_every > 0 && (k % flip_every) == flip_every - 1), 0);
    end
  endtask
  task automatic lock_count(input int en_pct, output int n);
    logic e;
    n = 0;
    for (int k = 0; k < 400 && !locked; k++) begin
      e = $urandom_range(99) < en_pct;
      if (e) n++;
      cyc(0, e, e ? next_gen() : 1'($urandom), 0);
    end
  endtask
  task automatic align();
    for (int k = 0; k < 70 && wpos != 0; k++) cyc(0, 1, next_gen(), 0);
  endtask
  initial begin
    int n;
    logic e, c, r, f, bb;
    @(negedge clk);
    for (int i = 0; i < 2; i++) cyc(1, 1, i % 2 == 1, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_bit_count", bit_count, 0);
    chk("rst_pass", pass, 0);
    g = 7'h01;
    lock_count(100, n);
    chk("lock_bits", n, 23);
    chk("lock_pass", pass, 1);
    feed(127, 0);
    chk("bit_count_127", bit_count, 127);
    chk("err_count_clean", err_count, 0);
    feed(49, 0);
    cyc(0, 1, ~next_gen(), 0);
    chk("single_pulse", err_pulse, 1);
    chk("single_count", err_count, 1);
    chk("single_pass", pass, 0);
    chk("single_locked", locked, 1);
    feed(100, 0);
    chk("single_after", err_count, 1);
    align();
    feed(3, 1);
    chk("three_locked", locked, 1);
    cyc(0, 1, ~next_gen(), 0);
    chk("loss_locked", locked, 0);
    lock_count(100, n);
    chk("relock_bits", n, 23);
    chk("relock_err_count", err_count, 0);
    feed(640, 22);
    chk("three_per_window_locked", locked, 1);
    cyc(1, 1, 0, 0);
    for (int k = 0; k < 200; k++) cyc(0, 1, 0, 0);
    chk("zeros_locked", locked, 0);
    cyc(1, 0, 0, 0);
    g = 7'h01;
    lock_count(70, n);
    chk("gap_lock_bits", n, 23);
    align();
    feed(6, 2);
    chk("clear_pre", err_count, 3);
    cyc(0, 1, next_gen(), 1);
    chk("clear_err_count", err_count, 0);
    chk("clear_bit_count", bit_count, 0);
    chk("clear_pass", pass, 1);
    align();
    cyc(0, 1, ~next_gen(), 1);
    chk("clear_mis_pulse", err_pulse, 1);
    chk("clear_mis_count", err_count, 0);
    cyc(1, 1, next_gen(), 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_bit_count", bit_count, 0);
    chk("midrst_pass", pass, 0);
    lock_count(100, n);
    chk("midrst_relock", n, 23);
    for (int k = 0; k < 3000; k++) begin
      e = $urandom_range(99) < 85;
      f = $urandom_range(99) < 2;
      c = $urandom_range(99) < 2;
      r = $urandom_range(999) < 3;
      bb = e ? next_gen() ^ f : 1'($urandom);
      cyc(r, e, bb, c);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
